// File: rtl/i2c_regbank_pkg.sv
// Shared constants for the I2C register bank: register addresses, CTRL/STATUS bit
// positions and reset values.
package i2c_regbank_pkg;

  localparam logic [7:0] ADDR_ID       = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h01;
  localparam logic [7:0] ADDR_STATUS   = 8'h02;
  localparam logic [7:0] ADDR_GPIO_OUT = 8'h03;
  localparam logic [7:0] ADDR_GPIO_IN  = 8'h04;
  localparam logic [7:0] ADDR_COUNT    = 8'h05;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h06;
  localparam logic [7:0] ADDR_SCRATCH0 = 8'h07;

  localparam int CTRL_CNT_EN  = 0;
  localparam int CTRL_CNT_CLR = 1;
  localparam int CTRL_LOCK    = 7;

  localparam int STAT_EVT    = 0;
  localparam int STAT_OVF    = 1;
  localparam int STAT_WR_ERR = 2;

  localparam logic [7:0] RST_CTRL     = 8'h00;
  localparam logic [2:0] RST_STATUS   = 3'b000;
  localparam logic [7:0] RST_GPIO_OUT = 8'h00;
  localparam logic [7:0] RST_COUNT    = 8'h00;
  localparam logic [7:0] RST_IRQ_MASK = 8'h00;
  localparam logic [7:0] RST_SCRATCH  = 8'h00;

endpackage

// File: rtl/i2c_regbank_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a rising-edge pulse taken
// from the synchronized value.
module i2c_regbank_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/i2c_regbank.sv
// Register bank behind the I2C slave application bus: ID, CTRL, sticky STATUS, GPIO,
// event counter and scratch. Define REGBANK_IRQ_EN to build IRQ_MASK and the irq output.
module i2c_regbank
  import i2c_regbank_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         NUM_SCRATCH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rw,
  input  logic [7:0] i_addr,
  input  logic       i_wen,
  input  logic [7:0] i_wdata,
  input  logic       i_rdata_used,
  output logic [7:0] o_rdata,
  input  logic [7:0] i_gpio_in,
  output logic [7:0] o_gpio_out,
  input  logic       i_event_in,
  output logic       o_irq
);

  logic [7:0] r_ctrl;
  logic [2:0] r_status;
  logic [7:0] r_gpio_out;
  logic [7:0] r_count;
  logic [7:0] r_scratch [NUM_SCRATCH];

  logic [7:0]             w_gpio_sync;
  logic [7:0]             w_gpio_rise;
  logic                   w_evt_sync;
  logic                   w_evt_rise;
  logic [NUM_SCRATCH-1:0] w_scr_sel;
  logic                   w_wr_ctrl;
  logic                   w_wr_gpio;
  logic                   w_wr_mask;
  logic                   w_wr_scr;
  logic                   w_wr_err;
  logic                   w_cnt_clr;
  logic                   w_cnt_inc;
  logic                   w_cnt_ovf;
  logic                   w_rd_clr;
  logic                   w_unused;

  i2c_regbank_sync #(.W(1)) u_evt_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_event_in),
    .o_q   (w_evt_sync),
    .o_rise(w_evt_rise)
  );

  i2c_regbank_sync #(.W(8)) u_gpio_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_gpio_in),
    .o_q   (w_gpio_sync),
    .o_rise(w_gpio_rise)
  );

  assign w_unused = ^{i_rw, w_gpio_rise, w_evt_sync};

  always_comb begin
    w_wr_ctrl = 1'b0;
    w_wr_gpio = 1'b0;
    w_wr_mask = 1'b0;
    w_wr_scr  = 1'b0;
    w_wr_err  = 1'b0;
    for (int n = 0; n < NUM_SCRATCH; n++) begin
      w_scr_sel[n] = (i_addr == ADDR_SCRATCH0 + 8'(n));
    end
    if (i_wen) begin
      case (i_addr)
        ADDR_CTRL:     w_wr_ctrl = 1'b1;
        ADDR_GPIO_OUT: if (r_ctrl[CTRL_LOCK]) w_wr_err = 1'b1; else w_wr_gpio = 1'b1;
`ifdef REGBANK_IRQ_EN
        ADDR_IRQ_MASK: if (r_ctrl[CTRL_LOCK]) w_wr_err = 1'b1; else w_wr_mask = 1'b1;
`else
        ADDR_IRQ_MASK: w_wr_mask = 1'b0;
`endif
        default: begin
          if (|w_scr_sel) begin
            if (r_ctrl[CTRL_LOCK]) w_wr_err = 1'b1; else w_wr_scr = 1'b1;
          end else begin
            w_wr_err = 1'b1;
          end
        end
      endcase
    end
  end

  // A clear in the same cycle as an edge leaves COUNT at zero.
  assign w_cnt_clr = w_wr_ctrl & i_wdata[CTRL_CNT_CLR];
  assign w_cnt_inc = w_evt_rise & r_ctrl[CTRL_CNT_EN] & ~w_cnt_clr;
  assign w_cnt_ovf = w_cnt_inc & (r_count == 8'hFF);
  assign w_rd_clr  = i_rdata_used & (i_addr == ADDR_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= RST_CTRL;
      r_status   <= RST_STATUS;
      r_gpio_out <= RST_GPIO_OUT;
      r_count    <= RST_COUNT;
      for (int n = 0; n < NUM_SCRATCH; n++) r_scratch[n] <= RST_SCRATCH;
    end else begin
      if (w_wr_ctrl) r_ctrl <= i_wdata & ~(8'h01 << CTRL_CNT_CLR);
      if (w_wr_gpio) r_gpio_out <= i_wdata;
      if (w_cnt_clr) r_count <= RST_COUNT;
      else if (w_cnt_inc) r_count <= r_count + 8'h01;
      // Set wins over clear-on-read.
      r_status <= (w_rd_clr ? RST_STATUS : r_status) | {w_wr_err, w_cnt_ovf, w_evt_rise};
      for (int n = 0; n < NUM_SCRATCH; n++) begin
        if (w_wr_scr && w_scr_sel[n]) r_scratch[n] <= i_wdata;
      end
    end
  end

`ifdef REGBANK_IRQ_EN
  logic [7:0] r_irq_mask;
  logic       r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_mask <= RST_IRQ_MASK;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_mask) r_irq_mask <= i_wdata;
      r_irq <= |(r_status & r_irq_mask[2:0]);
    end
  end

  assign o_irq = r_irq;
`else
  logic [7:0] r_irq_mask;
  assign r_irq_mask = RST_IRQ_MASK;
  assign o_irq      = 1'b0;
`endif

  always_comb begin
    o_rdata = 8'h00;
    case (i_addr)
      ADDR_ID:       o_rdata = ID_VALUE;
      ADDR_CTRL:     o_rdata = r_ctrl;
      ADDR_STATUS:   o_rdata = {5'b00000, r_status};
      ADDR_GPIO_OUT: o_rdata = r_gpio_out;
      ADDR_GPIO_IN:  o_rdata = w_gpio_sync;
      ADDR_COUNT:    o_rdata = r_count;
      ADDR_IRQ_MASK: o_rdata = r_irq_mask;
      default: begin
        for (int n = 0; n < NUM_SCRATCH; n++) begin
          if (w_scr_sel[n]) o_rdata = r_scratch[n];
        end
      end
    endcase
  end

  assign o_gpio_out = r_gpio_out;

endmodule
